dc_alu_stage_reg: RTL and testbench
===================================

// Module: dc_alu_stage_reg
// PURPOSE
//   Decode->ALU pipeline register with integrated load-use hazard control.
//   Captures decoded operands/control from the decode stage and drives the ALU stage.
//   Its ex_rs1/ex_rs2 outputs are the addr1/addr2 inputs of the forwarding unit.
//   Holds on memory stall, inserts one bubble on a load-use hazard, clears on branch flush.
// PARAMETERS
//   XLEN     32  data/PC width
//   RA_W     5   register address width
//   CTRL_W   8   opaque ALU/MEM/WB control bundle width
//   CNT_W    16  bubble counter width
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       async reset, active-high
//   flush        in   1       branch/jump taken in ALU stage; kill ALU-stage slot
//   ext_stall    in   1       memory not ready; freeze this register
//   id_valid     in   1       decode slot holds a real instruction
//   id_rs1       in   RA_W    source reg 1 address
//   id_rs2       in   RA_W    source reg 2 address
//   id_use_rs1   in   1       instruction reads rs1
//   id_use_rs2   in   1       instruction reads rs2
//   id_rd        in   RA_W    destination reg
//   id_reg_write in   1       instruction writes rd
//   id_is_load   in   1       instruction is a load
//   id_rs1_data  in   XLEN    register file read data 1
//   id_rs2_data  in   XLEN    register file read data 2
//   id_imm       in   XLEN    immediate
//   id_pc        in   XLEN    instruction PC
//   id_ctrl      in   CTRL_W  control bundle
//   stall_up     out  1       freeze PC and fetch->decode register (comb.)
//   ex_valid     out  1       ALU slot valid
//   ex_rs1       out  RA_W    to forwarding unit addr1
//   ex_rs2       out  RA_W    to forwarding unit addr2
//   ex_rd, ex_reg_write, ex_is_load, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_ctrl
//                out  (as id_*) registered copies
//   hz_state     out  2       FSM state (0 RUN, 1 BUBBLE, 2 HOLD), for debug
//   bubble_cnt   out  CNT_W   load-use bubbles inserted, saturating
// BEHAVIOUR
//   Reset (async, rst=1): all ex_* outputs, bubble_cnt = 0; hz_state = RUN.
//   load_use (comb.) = id_valid & ex_valid & ex_is_load & (ex_rd!=0) &
//     ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//   stall_up = ~flush & (ext_stall | load_use).
//   Bubble: ex_valid=0, ex_rd=ex_rs1=ex_rs2=0, ex_reg_write=0, ex_is_load=0, ex_ctrl=0.
//     Data fields don't-care; drive 0.
//     Zeroed addresses stop forwarding matches; the forwarding unit ignores x0.
//   Per rising edge, priority highest first:
//     1 flush: load bubble; state->RUN; ext_stall and load_use ignored.
//     2 ext_stall: hold every ex_* register; state->HOLD; no bubble counted.
//     3 load_use: load bubble; state->BUBBLE; bubble_cnt++ unless all-ones.
//     4 else: capture id_*; ex_valid<=id_valid; state->RUN.
//   Latency: one cycle decode->ALU.
//   Load-use costs exactly one bubble. Next cycle ex_valid=0, so load_use=0 and the held
//     decode instruction is captured. Its operand arrives via the forwarding unit's MEM path.
//   Leaving HOLD: first non-stalled edge re-evaluates load_use against the held ALU slot.
//   id_valid=0 never raises load_use. It is captured as a bubble with its fields as given.
//   Reset mid-stall or mid-bubble: immediate return to RUN with empty slot.
// TESTING
//   1 Reset: rst=1 mid-run -> ex_valid=0, bubble_cnt=0, hz_state=0 without a clock edge.
//   2 lw x5 then add x6,x5,x7 -> stall_up=1 one cycle; one bubble (ex_rd=0).
//     Next edge: ex_rs1=5, ex_valid=1, bubble_cnt=1.
//   3 lw x0 then add x6,x0,x1 -> no stall; lw x5 then addi (use_rs2=0, rs2=5) -> no stall.
//   4 ext_stall=1 for 3 cycles with add in slot -> ex_* frozen, hz_state=2.
//     Release -> capture next instruction.
//   5 flush=1 with load_use=1 and ext_stall=1 -> stall_up=0.
//     Slot becomes bubble; bubble_cnt unchanged.
//   6 CNT_W=2: 5 load-use hazards -> bubble_cnt saturates at 3.

Source files
------------

// File: rtl/dc_alu_stage_reg.sv
// Decode->ALU pipeline register with load-use hazard control: holds on memory stall,
// inserts a single bubble on a load-use hazard, and kills the slot on a branch flush.
//
//   state  | meaning
//   RUN    | normal capture, or a flush bubble was just loaded
//   BUBBLE | a load-use bubble was just inserted
//   HOLD   | slot frozen by ext_stall
module dc_alu_stage_reg #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              stall_up,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              valid_q, valid_d;
  logic [RA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              reg_write_q, reg_write_d, is_load_q, is_load_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic insert_bubble;

  // x0 as a load target never creates a dependency
  assign load_use = id_valid & valid_q & is_load_q & (rd_q != '0) &
                    ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));

  assign insert_bubble = flush | (~ext_stall & load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (flush)          state_d = ST_RUN;
    else if (ext_stall) state_d = ST_HOLD;
    else if (load_use)  state_d = ST_BUBBLE;
  end

  always_comb begin
    stall_up = ~flush & (ext_stall | load_use);
    hz_state = state_q;
  end

  always_comb begin
    valid_d      = valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    is_load_d    = is_load_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (insert_bubble) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      pc_d        = '0;
      ctrl_d      = '0;
    end else if (!ext_stall) begin
      valid_d     = id_valid;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      reg_write_d = id_reg_write;
      is_load_d   = id_is_load;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      pc_d        = id_pc;
      ctrl_d      = id_ctrl;
    end
    // flush bubbles are not load-use bubbles and are not counted
    if (!flush && !ext_stall && load_use && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      is_load_q    <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      is_load_q    <= is_load_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_is_load   = is_load_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign ex_ctrl      = ctrl_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_dc_alu_stage_reg.sv
// Bench for dc_alu_stage_reg: a default instance plus a CNT_W=2 instance share stimulus;
// expected slot contents are queued at drive time and compared after each edge.
module tb_dc_alu_stage_reg;

  logic clk = 1'b0;
  logic rst;
  logic flush, ext_stall, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [7:0]  id_ctrl;

  logic        stall_up, ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [7:0]  ex_ctrl;
  logic [1:0]  hz_state;
  logic [15:0] bubble_cnt;

  logic        s_stall_up, s_ex_valid, s_ex_reg_write, s_ex_is_load;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [31:0] s_ex_rs1_data, s_ex_rs2_data, s_ex_imm, s_ex_pc;
  logic [7:0]  s_ex_ctrl;
  logic [1:0]  s_hz_state;
  logic [1:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  dc_alu_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .stall_up(stall_up), .ex_valid(ex_valid), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_ctrl(ex_ctrl), .hz_state(hz_state), .bubble_cnt(bubble_cnt)
  );

  dc_alu_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .stall_up(s_stall_up), .ex_valid(s_ex_valid), .ex_rs1(s_ex_rs1),
    .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write),
    .ex_is_load(s_ex_is_load), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
    .ex_imm(s_ex_imm), .ex_pc(s_ex_pc), .ex_ctrl(s_ex_ctrl), .hz_state(s_hz_state),
    .bubble_cnt(s_bubble_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, ld;
    logic [31:0] d1, d2, imm, pc;
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic exp_t act_main();
    exp_t a;
    a.v = ex_valid; a.rs1 = ex_rs1; a.rs2 = ex_rs2; a.rd = ex_rd;
    a.rw = ex_reg_write; a.ld = ex_is_load; a.d1 = ex_rs1_data; a.d2 = ex_rs2_data;
    a.imm = ex_imm; a.pc = ex_pc; a.ctrl = ex_ctrl; a.st = hz_state;
    a.cnt = bubble_cnt; a.scnt = s_bubble_cnt;
    return a;
  endfunction

  function automatic exp_t act_sat();
    exp_t a;
    a.v = s_ex_valid; a.rs1 = s_ex_rs1; a.rs2 = s_ex_rs2; a.rd = s_ex_rd;
    a.rw = s_ex_reg_write; a.ld = s_ex_is_load; a.d1 = s_ex_rs1_data; a.d2 = s_ex_rs2_data;
    a.imm = s_ex_imm; a.pc = s_ex_pc; a.ctrl = s_ex_ctrl; a.st = s_hz_state;
    a.cnt = {14'b0, s_bubble_cnt}; a.scnt = s_bubble_cnt;
    return a;
  endfunction

  function automatic exp_t sat_view(input exp_t e);
    exp_t r = e;
    r.cnt = {14'b0, e.scnt};
    return r;
  endfunction

  function automatic exp_t bub(input exp_t c);
    exp_t b = '0;
    b.cnt  = c.cnt;
    b.scnt = c.scnt;
    return b;
  endfunction

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                           input logic rw, input logic ld);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_ctrl = 8'($urandom);
  endtask

  // Drives one cycle, queues the expected slot, clocks, and returns the queued entry.
  task automatic step(input logic fl, input logic st, output logic su_a,
                      output logic su_e, output exp_t e);
    logic lu;
    exp_t n;
    flush = fl; ext_stall = st;
    #1;
    lu = id_valid & m.v & m.ld & (m.rd != 5'd0) &
         ((id_use_rs1 & (id_rs1 == m.rd)) | (id_use_rs2 & (id_rs2 == m.rd)));
    su_e = ~fl & (st | lu);
    su_a = stall_up;
    n = m;
    if (fl) begin
      n = bub(m); n.st = 2'd0;
    end else if (st) begin
      n.st = 2'd2;
    end else if (lu) begin
      n = bub(m); n.st = 2'd1;
      if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
      if (n.scnt != 2'b11) n.scnt = n.scnt + 2'd1;
    end else begin
      n.v = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.rw = id_reg_write;
      n.ld = id_is_load; n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
      n.pc = id_pc; n.ctrl = id_ctrl; n.st = 2'd0;
    end
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    logic sa, se;
    exp_t e;
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    total++; if (act_main() !== e) begin bad++; $display("FAIL reset_lw: got %h want %h", act_main(), e); end
    set_instr(1, 5, 1, 7, 1, 6, 1, 0);
    repeat (2) begin
      step(0, 0, sa, se, e);
      total++; if (act_main() !== e) begin bad++; $display("FAIL reset_pre: got %h want %h", act_main(), e); end
    end
    #2 rst = 1'b1;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", hz_state); end
    total++; if (ex_rd !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", ex_rd); end
    m = '0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_load_use();
    logic sa, se;
    exp_t e;
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    total++; if (act_main() !== e) begin bad++; $display("FAIL lu_lw: got %h want %h", act_main(), e); end
    set_instr(1, 5, 1, 7, 1, 6, 1, 0);
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b1) begin bad++; $display("FAIL lu_stall_up: got %b want 1", sa); end
    total++; if (ex_rd !== 5'd0 || ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: got rd=%0d v=%b want rd=0 v=0", ex_rd, ex_valid); end
    total++; if (act_main() !== e) begin bad++; $display("FAIL lu_bubble_slot: got %h want %h", act_main(), e); end
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", sa); end
    total++; if (ex_rs1 !== 5'd5 || ex_valid !== 1'b1 || bubble_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_capture: got rs1=%0d v=%b cnt=%0d want rs1=5 v=1 cnt=1", ex_rs1, ex_valid, bubble_cnt);
    end
    total++; if (act_main() !== e) begin bad++; $display("FAIL lu_capture_slot: got %h want %h", act_main(), e); end
  endtask

  task automatic test_no_hazard();
    logic sa, se;
    exp_t e;
    set_instr(1, 1, 1, 2, 1, 0, 0, 1);
    step(0, 0, sa, se, e);
    set_instr(1, 0, 1, 1, 1, 6, 1, 0);
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL nh_x0: got stall_up=%b want 0", sa); end
    total++; if (act_main() !== e) begin bad++; $display("FAIL nh_x0_slot: got %h want %h", act_main(), e); end
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    set_instr(1, 2, 1, 5, 0, 6, 1, 0);
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL nh_unused_rs2: got stall_up=%b want 0", sa); end
    total++; if (act_main() !== e) begin bad++; $display("FAIL nh_addi_slot: got %h want %h", act_main(), e); end
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    set_instr(0, 5, 1, 5, 1, 9, 1, 0);
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL nh_invalid: got stall_up=%b want 0", sa); end
    total++; if (ex_valid !== 1'b0 || ex_rd !== 5'd9) begin bad++; $display("FAIL nh_invalid_cap: got v=%b rd=%0d want v=0 rd=9", ex_valid, ex_rd); end
    total++; if (act_main() !== e) begin bad++; $display("FAIL nh_invalid_slot: got %h want %h", act_main(), e); end
  endtask

  task automatic test_ext_stall();
    logic sa, se;
    exp_t e;
    set_instr(1, 1, 1, 2, 1, 6, 1, 0);
    step(0, 0, sa, se, e);
    set_instr(1, 3, 1, 4, 1, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, sa, se, e);
      total++; if (sa !== 1'b1) begin bad++; $display("FAIL st_stall_up[%0d]: got %b want 1", i, sa); end
      total++; if (hz_state !== 2'd2 || ex_rd !== 5'd6) begin bad++; $display("FAIL st_frozen[%0d]: got st=%0d rd=%0d want st=2 rd=6", i, hz_state, ex_rd); end
      total++; if (act_main() !== e) begin bad++; $display("FAIL st_slot[%0d]: got %h want %h", i, act_main(), e); end
    end
    step(0, 0, sa, se, e);
    total++; if (ex_rd !== 5'd8 || hz_state !== 2'd0) begin bad++; $display("FAIL st_release: got rd=%0d st=%0d want rd=8 st=0", ex_rd, hz_state); end
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    set_instr(1, 5, 1, 0, 0, 7, 1, 0);
    step(0, 1, sa, se, e);
    step(0, 0, sa, se, e);
    total++; if (sa !== 1'b1 || hz_state !== 2'd1 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL st_reeval: got su=%b st=%0d v=%b want su=1 st=1 v=0", sa, hz_state, ex_valid);
    end
    total++; if (act_main() !== e) begin bad++; $display("FAIL st_reeval_slot: got %h want %h", act_main(), e); end
    step(0, 0, sa, se, e);
    total++; if (act_main() !== e) begin bad++; $display("FAIL st_after: got %h want %h", act_main(), e); end
  endtask

  task automatic test_flush();
    logic sa, se;
    exp_t e;
    logic [15:0] c0;
    set_instr(1, 1, 1, 0, 0, 5, 1, 1);
    step(0, 0, sa, se, e);
    c0 = bubble_cnt;
    set_instr(1, 5, 1, 5, 1, 7, 1, 0);
    step(1, 1, sa, se, e);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL fl_stall_up: got %b want 0", sa); end
    total++; if (ex_valid !== 1'b0 || hz_state !== 2'd0 || bubble_cnt !== c0) begin
      bad++; $display("FAIL fl_slot: got v=%b st=%0d cnt=%0d want v=0 st=0 cnt=%0d", ex_valid, hz_state, bubble_cnt, c0);
    end
    total++; if (act_main() !== e) begin bad++; $display("FAIL fl_bundle: got %h want %h", act_main(), e); end
    step(0, 0, sa, se, e);
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin bad++; $display("FAIL fl_after: got v=%b rd=%0d want v=1 rd=7", ex_valid, ex_rd); end
  endtask

  task automatic test_saturation();
    logic sa, se;
    exp_t e;
    logic [15:0] c0;
    c0 = bubble_cnt;
    for (int i = 0; i < 5; i++) begin
      set_instr(1, 2, 1, 0, 0, 5, 1, 1);
      step(0, 0, sa, se, e);
      set_instr(1, 3, 1, 5, 1, 4, 1, 0);
      step(0, 0, sa, se, e);
      total++; if (act_sat() !== sat_view(e)) begin bad++; $display("FAIL sat_slot[%0d]: got %h want %h", i, act_sat(), sat_view(e)); end
    end
    total++; if (s_bubble_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", s_bubble_cnt); end
    total++; if (bubble_cnt !== c0 + 16'd5) begin bad++; $display("FAIL sat_wide_cnt: got %0d want %0d", bubble_cnt, c0 + 16'd5); end
  endtask

  task automatic test_back_to_back();
    logic sa, se;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      set_instr(logic'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 5) == 0), sa, se, e);
      total++; if (sa !== se) begin bad++; $display("FAIL b2b_stall_up[%0d]: got %b want %b", i, sa, se); end
      total++; if (act_main() !== e) begin bad++; $display("FAIL b2b_slot[%0d]: got %h want %h", i, act_main(), e); end
      total++; if (act_sat() !== sat_view(e)) begin bad++; $display("FAIL b2b_sat[%0d]: got %h want %h", i, act_sat(), sat_view(e)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_ext_stall();
    test_flush();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
